// File: rtl/breath_ramp_if.sv
`default_nettype none
// ============================================================================
// Module   : breath_ramp_if
// Brief    : Enable input and duty/frame outputs of the breathing ramp source.
//            The master modport is the ramp generator. The slave modport is the
//            PWM stage, which also drives the enable.
// Revision : 1.0 - initial release
// ============================================================================
interface breath_ramp_if #(
  parameter int DW = 10
);
  logic          en;
  logic [DW-1:0] frame_pos;
  logic          frame_tick;
  logic [DW-1:0] duty;
  logic [2:0]    state;
  logic          cycle_done;

  modport master (
    input  en,
    output frame_pos, frame_tick, duty, state, cycle_done
  );

  modport slave (
    output en,
    input  frame_pos, frame_tick, duty, state, cycle_done
  );
endinterface
`default_nettype wire

// File: rtl/breath_ramp_gen.sv
`default_nettype none
// ============================================================================
// Module   : breath_ramp_gen
// Brief    : 1 us prescaler, K-us PWM frame counter and triangular duty ramp
//            (rise / hold high / fall / hold low). Duty only moves at frame
//            wraps, except that dropping en forces it to 0 at once.
// Revision : 1.0 - initial release
// ============================================================================
module breath_ramp_gen #(
  parameter int CLK_PER_US  = 34,
  parameter int K           = 1000,
  parameter int DW          = 10,
  parameter int STEP        = 1,
  parameter int HOLD_FRAMES = 0
) (
  input  logic         s_clk,
  input  logic         s_rst,
  breath_ramp_if.master bus
);

  localparam int c_PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int c_HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [c_PW-1:0] c_PRE_MAX   = c_PW'(CLK_PER_US - 1);
  localparam logic [DW-1:0]   c_POS_MAX   = DW'(K - 1);
  // A STEP larger than full scale behaves the same as a STEP of K-1.
  // Clamping it keeps the arithmetic inside DW+1 bits.
  localparam logic [DW-1:0]   c_STEP      = DW'((STEP > K - 1) ? K - 1 : STEP);
  localparam logic [31:0]     c_HOLD_LAST = (HOLD_FRAMES > 0) ? HOLD_FRAMES - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RISE    = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_FALL    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_t;

  logic [c_PW-1:0] r_pre;
  logic [DW-1:0]   r_frame_pos;
  logic            r_frame_tick;
  logic [DW-1:0]   r_duty;
  logic [c_HW-1:0] r_hold_cnt;
  logic            r_cycle_done;
  state_t          r_state;

  logic            w_pre_wrap;
  logic            w_frame_wrap;
  logic [DW:0]     w_sum;
  state_t          w_state_nxt;
  logic [DW-1:0]   w_duty_nxt;
  logic [c_HW-1:0] w_hold_nxt;
  logic            w_done_nxt;

  assign w_pre_wrap   = (r_pre == c_PRE_MAX);
  assign w_frame_wrap = w_pre_wrap && (r_frame_pos == c_POS_MAX);

  // Free-running timebase: 1 us prescaler, then the in-frame microsecond position.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_pre        <= '0;
      r_frame_pos  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_pre        <= w_pre_wrap ? '0 : r_pre + c_PW'(1);
      r_frame_tick <= w_frame_wrap;
      if (w_pre_wrap) begin
        r_frame_pos <= (r_frame_pos == c_POS_MAX) ? '0 : r_frame_pos + DW'(1);
      end
    end
  end

  // Ramp state register: duty, hold counter and the breath-complete pulse.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_state      <= ST_IDLE;
      r_duty       <= '0;
      r_hold_cnt   <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_duty       <= w_duty_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_cycle_done <= w_done_nxt;
    end
  end

  // Next ramp step. A low en overrides everything, including a coincident frame wrap.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_hold_nxt  = r_hold_cnt;
    w_done_nxt  = 1'b0;
    w_sum       = {1'b0, r_duty} + {1'b0, c_STEP};
    if (!bus.en) begin
      w_state_nxt = ST_IDLE;
      w_duty_nxt  = '0;
      w_hold_nxt  = '0;
    end else if (w_frame_wrap) begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_RISE;
          w_duty_nxt  = c_STEP;
        end
        ST_RISE: begin
          if (w_sum >= {1'b0, c_POS_MAX}) begin
            w_duty_nxt  = c_POS_MAX;
            w_hold_nxt  = '0;
            w_state_nxt = (HOLD_FRAMES == 0) ? ST_FALL : ST_HOLD_HI;
          end else begin
            w_duty_nxt = w_sum[DW-1:0];
          end
        end
        ST_HOLD_HI: begin
          if (32'(r_hold_cnt) >= c_HOLD_LAST) begin
            w_hold_nxt  = '0;
            w_state_nxt = ST_FALL;
          end else begin
            w_hold_nxt = r_hold_cnt + c_HW'(1);
          end
        end
        ST_FALL: begin
          if (r_duty <= c_STEP) begin
            w_duty_nxt  = '0;
            w_done_nxt  = 1'b1;
            w_hold_nxt  = '0;
            w_state_nxt = (HOLD_FRAMES == 0) ? ST_RISE : ST_HOLD_LO;
          end else begin
            w_duty_nxt = r_duty - c_STEP;
          end
        end
        ST_HOLD_LO: begin
          if (32'(r_hold_cnt) >= c_HOLD_LAST) begin
            w_hold_nxt  = '0;
            w_state_nxt = ST_RISE;
          end else begin
            w_hold_nxt = r_hold_cnt + c_HW'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = '0;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  assign bus.frame_pos  = r_frame_pos;
  assign bus.frame_tick = r_frame_tick;
  assign bus.duty       = r_duty;
  assign bus.state      = r_state;
  assign bus.cycle_done = r_cycle_done;

endmodule
`default_nettype wire

// File: tb/tb_breath_ramp_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_breath_ramp_gen
// Brief    : Directed bench for breath_ramp_gen. Three instances share one clock:
//            u0 uses STEP=1 with no holds, u1 uses STEP=1 with HOLD_FRAMES=2,
//            and u2 uses STEP=4 with no holds. All use CLK_PER_US=3 and K=10,
//            so a frame is 30 cycles. Expected values are written against
//            edge numbers counted from reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_breath_ramp_gen;

  logic s_clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   now   = 0;

  breath_ramp_if #(.DW(10)) bus0 ();
  breath_ramp_if #(.DW(10)) bus1 ();
  breath_ramp_if #(.DW(10)) bus2 ();

  breath_ramp_gen #(.CLK_PER_US(3), .K(10), .DW(10), .STEP(1), .HOLD_FRAMES(0)) u0 (
    .s_clk(s_clk), .s_rst(rst_a), .bus(bus0));
  breath_ramp_gen #(.CLK_PER_US(3), .K(10), .DW(10), .STEP(1), .HOLD_FRAMES(2)) u1 (
    .s_clk(s_clk), .s_rst(rst_b), .bus(bus1));
  breath_ramp_gen #(.CLK_PER_US(3), .K(10), .DW(10), .STEP(4), .HOLD_FRAMES(0)) u2 (
    .s_clk(s_clk), .s_rst(rst_a), .bus(bus2));

  // Clock generation.
  always #5 s_clk = ~s_clk;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after edge e, counted from reset release.
  task automatic adv(input int e);
    repeat (e - now) @(posedge s_clk);
    now = e;
    #1;
  endtask

  // Directed stimulus and checks, in time order.
  initial begin
    bus0.en = 1'b1;
    bus1.en = 1'b1;
    bus2.en = 1'b1;
    repeat (3) @(posedge s_clk);
    #1;
    chk("rst_duty0", bus0.duty, 0);
    chk("rst_state0", bus0.state, 0);
    chk("rst_pos0", bus0.frame_pos, 0);
    chk("rst_tick0", bus0.frame_tick, 0);
    chk("rst_done1", bus1.cycle_done, 0);
    chk("rst_duty2", bus2.duty, 0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    now   = 0;

    adv(29);  chk("pre_tick", bus0.frame_tick, 0);  chk("pos_k1", bus0.frame_pos, 9);
    adv(30);  chk("tick1", bus0.frame_tick, 1);     chk("pos_wrap", bus0.frame_pos, 0);
              chk("u0_d1", bus0.duty, 1);           chk("u0_s1", bus0.state, 1);
              chk("u1_d1", bus1.duty, 1);           chk("u2_d4", bus2.duty, 4);
              chk("u2_tick", bus2.frame_tick, 1);
    adv(31);  chk("tick_pulse", bus0.frame_tick, 0);
    adv(45);  chk("pos_mid", bus0.frame_pos, 5);
    adv(60);  chk("u0_d2", bus0.duty, 2);           chk("u2_d8", bus2.duty, 8);
    adv(90);  chk("tick3", bus0.frame_tick, 1);     chk("u2_d9", bus2.duty, 9);
              chk("u2_fall", bus2.state, 3);
    adv(120); chk("u2_d5", bus2.duty, 5);
    adv(150); chk("u2_d1", bus2.duty, 1);
    adv(180); chk("u2_d0", bus2.duty, 0);           chk("u2_done", bus2.cycle_done, 1);
              chk("u2_rise", bus2.state, 1);
    adv(181); chk("u2_done_pulse", bus2.cycle_done, 0);
    adv(210); chk("u2_d4b", bus2.duty, 4);
    adv(270); chk("u0_d9", bus0.duty, 9);           chk("u0_fall", bus0.state, 3);
              chk("u1_d9", bus1.duty, 9);           chk("u1_hold_hi", bus1.state, 2);
    adv(300); chk("u0_d8", bus0.duty, 8);
              chk("u1_hold_d", bus1.duty, 9);       chk("u1_hold_s", bus1.state, 2);
    adv(330); chk("u1_fall_d", bus1.duty, 9);       chk("u1_fall_s", bus1.state, 3);
              chk("u2_pre_d1", bus2.duty, 1);       chk("u2_pre_s", bus2.state, 3);
    adv(359); bus2.en = 1'b0;
    adv(360); chk("u2_en_wrap_s", bus2.state, 0);   chk("u2_en_wrap_d", bus2.duty, 0);
              chk("u2_en_wrap_cd", bus2.cycle_done, 0);
              chk("u2_tick_on", bus2.frame_tick, 1);
    adv(361); chk("u2_cd_after", bus2.cycle_done, 0);
    adv(390); chk("u2_idle_s", bus2.state, 0);      chk("u2_idle_d", bus2.duty, 0);
    adv(510); chk("u0_d1_fall", bus0.duty, 1);
    adv(540); chk("u0_d0", bus0.duty, 0);           chk("u0_done", bus0.cycle_done, 1);
              chk("u0_rise2", bus0.state, 1);       chk("u1_d2", bus1.duty, 2);
    adv(570); chk("u0_d1_again", bus0.duty, 1);     chk("u0_done_off", bus0.cycle_done, 0);
    adv(600); chk("u1_d0", bus1.duty, 0);           chk("u1_done", bus1.cycle_done, 1);
              chk("u1_hold_lo", bus1.state, 4);
    adv(630); chk("u1_hlo_s", bus1.state, 4);       chk("u1_hlo_d", bus1.duty, 0);
    adv(660); chk("u1_rise_s", bus1.state, 1);      chk("u1_rise_d0", bus1.duty, 0);
    adv(690); chk("u1_rise_d1", bus1.duty, 1);
    adv(720); chk("u0_d6", bus0.duty, 6);           chk("u0_s_rise", bus0.state, 1);
    adv(730); bus0.en = 1'b0;
    adv(731); chk("u0_drop_d", bus0.duty, 0);       chk("u0_drop_s", bus0.state, 0);
    adv(740); bus0.en = 1'b1;
    adv(749); chk("u0_wait_tick", bus0.frame_tick, 0);
              chk("u0_wait_d", bus0.duty, 0);       chk("u0_wait_s", bus0.state, 0);
    adv(750); chk("u0_cad_tick", bus0.frame_tick, 1);
              chk("u0_re_d", bus0.duty, 1);         chk("u0_re_s", bus0.state, 1);
    adv(930); chk("u1_hh2_s", bus1.state, 2);       chk("u1_hh2_d", bus1.duty, 9);
    adv(945); rst_b = 1'b0;
    #1;
    chk("arst_d", bus1.duty, 0);                    chk("arst_s", bus1.state, 0);
    chk("arst_pos", bus1.frame_pos, 0);             chk("arst_tick", bus1.frame_tick, 0);
    chk("arst_cd", bus1.cycle_done, 0);
    adv(947); rst_b = 1'b1;
    adv(976); chk("arst_pre_tick", bus1.frame_tick, 0);
    adv(977); chk("arst_tick30", bus1.frame_tick, 1);
              chk("arst_d1", bus1.duty, 1);         chk("arst_s1", bus1.state, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
